// File: rtl/layer0_input_loader.sv
// Serial feature loader: packs FEAT_BITS-wide beats into a NUM_FEAT-slot vector for layer0.
// Assembly buffer and output register are decoupled so the next frame fills while a vector is held.
module layer0_input_loader #(
  parameter int NUM_FEAT  = 24,
  parameter int FEAT_BITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [NUM_FEAT*FEAT_BITS-1:0] m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          err_short,
  output logic                          err_long,
  output logic [7:0]                    err_count
);
  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  logic [IDX_W-1:0]                    r_idx;
  logic                                r_complete;
  logic                                r_live;
  logic [NUM_FEAT-1:0][FEAT_BITS-1:0]  r_buf;
  logic [NUM_FEAT*FEAT_BITS-1:0]       r_mdata;
  logic                                r_mvalid;
  logic                                r_err_short;
  logic                                r_err_long;
  logic [7:0]                          r_err_count;

  logic w_accept, w_at_end, w_done, w_short, w_long, w_xfer;

  // r_live holds s_ready low until the first edge after reset release
  assign s_ready  = r_live && !r_complete;
  assign w_accept = s_valid && s_ready;
  assign w_at_end = (r_idx == LAST_IDX);
  assign w_done   = w_accept && (s_last || w_at_end);
  assign w_short  = w_accept && s_last && !w_at_end;
  assign w_long   = w_accept && w_at_end && !s_last;
  assign w_xfer   = r_complete && (!r_mvalid || m_ready);

  assign m_data    = r_mdata;
  assign m_valid   = r_mvalid;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign err_count = r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_complete  <= 1'b0;
      r_live      <= 1'b0;
      r_buf       <= '0;
      r_mdata     <= '0;
      r_mvalid    <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_live      <= 1'b1;
      r_err_short <= w_short;
      r_err_long  <= w_long;
      if ((w_short || w_long) && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;

      // accept and transfer never coincide: accept needs !complete, transfer needs complete
      if (w_accept) begin
        r_buf[r_idx] <= s_data;
        r_idx        <= w_done ? '0 : r_idx + IDX_W'(1);
        if (w_done) r_complete <= 1'b1;
      end

      if (w_xfer) begin
        r_mdata    <= r_buf;
        r_mvalid   <= 1'b1;
        r_complete <= 1'b0;
        r_buf      <= '0;
      end else if (m_ready) begin
        r_mvalid   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_layer0_input_loader.sv
// Bench for layer0_input_loader: frame-level reference model (feature lists -> vectors, error tallies).
module tb_layer0_input_loader;
  localparam int N = 24;
  localparam int B = 2;
  localparam int W = N * B;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [B-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         err_short, err_long;
  logic [7:0]   err_count;

  layer0_input_loader #(.NUM_FEAT(N), .FEAT_BITS(B)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_short(err_short), .err_long(err_long), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [W-1:0] exp_q[$], got_q[$];
  int cur[$];
  int exp_short, exp_long, exp_cnt, seen_short, seen_long, stab_viol;
  bit prev_hold, rand_bp;
  logic [W-1:0] prev_data;

  // Reference: a frame is the accepted features up to s_last or N of them, zero-padded.
  function automatic void model_beat(int d, bit last);
    logic [W-1:0] v;
    int n;
    cur.push_back(d);
    n = cur.size();
    if (last || n == N) begin
      v = '0;
      for (int k = 0; k < n; k++) v[k*B +: B] = B'(cur[k]);
      exp_q.push_back(v);
      if ((last && n < N) || (!last && n == N)) begin
        if (last) exp_short++; else exp_long++;
        if (exp_cnt < 255) exp_cnt++;
      end
      cur.delete();
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete(); got_q.delete(); cur.delete();
    exp_short = 0; exp_long = 0; exp_cnt = 0;
    seen_short = 0; seen_long = 0; stab_viol = 0; prev_hold = 0;
  endfunction

  function automatic int sb_errs();
    int e = 0;
    if (got_q.size() != exp_q.size()) e++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  // Observe handshakes mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (prev_hold && m_data !== prev_data) stab_viol++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (s_valid && s_ready) model_beat(int'(s_data), s_last);
      if (err_short) seen_short++;
      if (err_long) seen_long++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_beat(input logic [B-1:0] d, input bit last);
    bit acc = 0;
    if (rand_bp) repeat ($urandom_range(0, 2)) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int t = 0; t < 500 && !acc; t++) begin
      if (rand_bp) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL send_beat_timeout got=no_accept want=accept"); end
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (N + 8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_m_data got=%h want=0", m_data); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got=%0d want=0", err_count); end
    checks++; if ({err_short, err_long} !== 2'b00) begin errors++; $display("FAIL rst_err got=%b want=00", {err_short, err_long}); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    rst = 1'b0;
    model_clear();
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready got=%b want=0", s_ready); end
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL first_edge_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_full_frame();
    logic [W-1:0] v = '0;
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      v[k*B +: B] = B'(k % 4);
      send_beat(B'(k % 4), k == N - 1);
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got=%b want=0", m_valid); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL full_latency got=%b want=1", m_valid); end
    checks++; if (m_data !== v) begin errors++; $display("FAIL full_data got=%h want=%h", m_data, v); end
    drain();
    checks++; if (seen_short + seen_long != 0 || err_count !== 8'd0) begin
      errors++; $display("FAIL full_no_err got=%0d/%0d/%0d want=0/0/0", seen_short, seen_long, err_count); end
    checks++; if (sb_errs() != 0) begin errors++; $display("FAIL full_sb got=%0d want=%0d vectors", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] va = '0, vb = '0;
    logic [B-1:0] d;
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < N; k++) begin d = B'($urandom); va[k*B +: B] = d; send_beat(d, k == N - 1); end
    for (int k = 0; k < N; k++) begin d = B'($urandom); vb[k*B +: B] = d; send_beat(d, k == N - 1); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b want=0", s_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== va) begin
      errors++; $display("FAIL bp_hold got=%b/%h want=1/%h", m_valid, m_data, va); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", stab_viol); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b1 || m_data !== vb) begin
      errors++; $display("FAIL bp_swap got=%b/%h want=1/%h", m_valid, m_data, vb); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_clear got=%b want=0", m_valid); end
    drain();
    checks++; if (got_q.size() != 2 || sb_errs() != 0) begin
      errors++; $display("FAIL bp_sb got=%0d want=2 vectors", got_q.size()); end
  endtask

  task automatic test_short();
    logic [W-1:0] v = W'(10'h3FF);
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_beat(2'b11, k == 4);
    @(posedge clk); #1;
    checks++; if (m_data !== v) begin errors++; $display("FAIL short_data got=%h want=%h", m_data, v); end
    drain();
    checks++; if (seen_short != 1 || seen_long != 0) begin
      errors++; $display("FAIL short_pulse got=%0d/%0d want=1/0", seen_short, seen_long); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL short_count got=%0d want=1", err_count); end
  endtask

  task automatic test_long();
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 30; k++) send_beat(B'($urandom), k == 29);
    drain();
    checks++; if (seen_short != 1 || seen_long != 1) begin
      errors++; $display("FAIL long_pulses got=%0d/%0d want=1/1", seen_short, seen_long); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL long_count got=%0d want=2", err_count); end
    checks++; if (got_q.size() != 2 || sb_errs() != 0) begin
      errors++; $display("FAIL long_sb got=%0d want=2 vectors", got_q.size()); end
  endtask

  task automatic test_saturation();
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 260; k++) send_beat(B'($urandom), 1'b1);
    drain();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d want=255", err_count); end
    checks++; if (seen_short != 260) begin errors++; $display("FAIL sat_pulses got=%0d want=260", seen_short); end
    checks++; if (sb_errs() != 0) begin errors++; $display("FAIL sat_sb got=%0d want=%0d vectors", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < N; k++) send_beat(B'($urandom_range(1, 3)), k == N - 1);
    for (int k = 0; k < 10; k++) send_beat(B'($urandom_range(1, 3)), 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== '0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_async got=%b/%h/%b want=0/0/0", m_valid, m_data, s_ready); end
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) send_beat(B'($urandom), k == N - 1);
    drain();
    checks++; if (got_q.size() != 1 || sb_errs() != 0) begin
      errors++; $display("FAIL mid_rst_sb got=%0d want=1 vectors", got_q.size()); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_rst_count got=%0d want=0", err_count); end
  endtask

  task automatic test_random();
    do_reset();
    rand_bp = 1'b1;
    for (int k = 0; k < 400; k++) send_beat(B'($urandom), $urandom_range(0, 19) == 0);
    rand_bp = 1'b0;
    drain();
    checks++; if (sb_errs() != 0) begin errors++; $display("FAIL rand_sb got=%0d want=%0d vectors", got_q.size(), exp_q.size()); end
    checks++; if (seen_short != exp_short || seen_long != exp_long) begin
      errors++; $display("FAIL rand_pulses got=%0d/%0d want=%0d/%0d", seen_short, seen_long, exp_short, exp_long); end
    checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL rand_count got=%0d want=%0d", err_count, exp_cnt); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_stable got=%0d want=0", stab_viol); end
  endtask

  initial begin
    model_clear();
    rand_bp = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short();
    test_long();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer0_input_loader.md
LAYER0_INPUT_LOADER -- requirements
Module: layer0_input_loader

Interface
REQ-001 Parameter NUM_FEAT, default 24: quantized features per input vector (range 2..64).
REQ-002 Parameter FEAT_BITS, default 2: bits per quantized feature (range 1..4).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s_data  input  FEAT_BITS  one quantized feature.
REQ-006 s_valid  input  1  s_data/s_last valid.
REQ-007 s_last  input  1  marks final feature of a frame.
REQ-008 s_ready  output  1  loader accepts a feature this cycle.
REQ-009 m_data  output  NUM_FEAT*FEAT_BITS  packed vector to layer0; feature k at bits [k*FEAT_BITS +: FEAT_BITS].
REQ-010 m_valid  output  1  m_data holds a complete vector.
REQ-011 m_ready  input  1  layer0 side consumes the vector.
REQ-012 err_short  output  1  one-cycle pulse: frame ended early by s_last.
REQ-013 err_long  output  1  one-cycle pulse: frame reached NUM_FEAT features without s_last.
REQ-014 err_count  output  8  saturating count of err_short plus err_long events.

Function
REQ-015 Input beat accepted iff s_valid && s_ready on a rising edge.
REQ-016 Assembly buffer and output register are separate, so a new frame fills while m_data is held.
REQ-017 Write index idx, 0..NUM_FEAT-1; accepted feature written to slot idx; idx increments per beat.
REQ-018 Frame completes on an accepted beat with s_last=1, or on an accepted beat with idx==NUM_FEAT-1.
REQ-019 On completion, flag complete sets and idx returns to 0.
REQ-020 s_ready = !complete; no beats are accepted while an assembled frame awaits transfer.
REQ-021 Transfer: in a cycle with complete=1 and (m_valid==0 || m_ready==1), copy the buffer to m_data, set m_valid, clear complete, and zero the buffer.
REQ-022 Latency: completing beat accepted at edge t -> m_valid=1 after edge t+1 when output is free. Otherwise after the edge that consumes the previous vector.
REQ-023 m_valid clears on m_ready when no transfer occurs the same cycle.
REQ-024 Simultaneous consume and transfer: m_valid stays 1 and m_data updates to the new vector.
REQ-025 m_data is stable while m_valid && !m_ready.
REQ-026 Early s_last at idx<NUM_FEAT-1: unfilled slots are 0; err_short pulses at the edge after the completing beat.
REQ-027 Beat at idx==NUM_FEAT-1 without s_last: frame completes normally and err_long pulses.
REQ-028 After err_long, following beats start a new frame; no dropping or resync is performed.
REQ-029 s_last at idx==NUM_FEAT-1 is a normal frame: no error.
REQ-030 err_short and err_long are mutually exclusive per frame.
REQ-031 err_count increments by 1 per error pulse and saturates at 255.
REQ-032 Throughput: one frame per NUM_FEAT+1 cycles under continuous s_valid and m_ready.

Reset
REQ-033 rst=1 asynchronously clears idx, complete, buffer, m_data=0, m_valid=0, err_short=0, err_long=0, err_count=0.
REQ-034 While rst=1, s_ready=0.
REQ-035 s_ready=1 from the first edge after rst deasserts.
REQ-036 Reset mid-frame or mid-hold discards all partial and pending data; no m_valid is produced for them.

Verification
REQ-037 Full frame: 24 beats, s_data=k mod 4, s_last on beat 23, m_ready=1 -> m_valid one cycle after beat 23; m_data slot k = k mod 4; no error.
REQ-038 Backpressure: hold m_ready=0 and send two full frames -> first vector held stable; s_ready=0 after the second completes; raise m_ready -> second vector appears the next cycle; zero beats are lost.
REQ-039 Short frame: 5 beats of 2'b11 with s_last on beat 4 -> m_data low 10 bits all 1, rest 0; err_short pulses once; err_count=1.
REQ-040 Long frame: 30 beats, s_last on the last -> frame 1 has 24 features and err_long=1; frame 2 has 6 features and err_short=1; err_count=2.
REQ-041 Saturation: 260 one-beat s_last frames -> err_count=255.
REQ-042 Reset mid-frame: rst pulse after 10 beats -> all outputs 0; next 24-beat frame is packed from slot 0 with no stale data.
